ctx_mover: RTL and testbench
============================

Name: ctx_mover

Overview:
- Bus initiator for the memory-mapped register-window responder on the shared `mem_we` / `mem_addr` / `mem_data` bus.
- On command, it saves the core register file into the GPR window (0xffffc000–0xffffc07c), or restores the register file from it.
- Sits between the core's register-file side port and the shared bus; used for trap entry/exit context switching.
- x0 is never transferred.

Parameters:
- GPR_BASE, 32'hffffc000, byte address of GPR window word 0
- TMP_BASE, 32'hffffc080, byte address of temp window word 0 (used only with CTX_TMP_EN)
- FIRST_IDX, 1, first register index transferred
- LAST_IDX, 31, last register index transferred

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE; command accepted when cmd_valid && cmd_ready
- cmd_op  in  1  0 = save (RF to memory), 1 = restore (memory to RF); sampled at accept
- busy  out  1  high while a command is in progress (XFER or DONE)
- done  out  1  one-cycle pulse at completion
- bus_req  out  1  bus request to arbiter
- bus_gnt  in  1  bus grant; transfer happens only in cycles where it is high
- mem_we  out  1  bus write strobe
- mem_addr  out  32  bus byte address
- mem_data  inout  32  driven only when mem_we=1, otherwise high-Z
- rf_raddr  out  5  register-file read index (combinational read)
- rf_rdata  in  32  register-file read data
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write index
- rf_wdata  out  32  register-file write data

Behaviour:
- One clock; reset is synchronous and active-high.
- Registered state: `state` (IDLE, XFER, DONE), `op`, 6-bit `idx`.
- Reset (also when asserted mid-transfer): state=IDLE, idx=FIRST_IDX.
  - Outputs at reset: cmd_ready=1, busy=0, done=0, bus_req=0, mem_we=0, mem_addr=0, mem_data=Z, rf_we=0, rf_raddr=0, rf_waddr=0, rf_wdata=0.
  - Partial restores are not rolled back.
- IDLE:
  - cmd_ready=1.
  - On accept: latch op, idx=FIRST_IDX, go to XFER.
  - cmd_valid while not in IDLE is ignored (not queued).
- XFER:
  - bus_req=1, busy=1.
  - A granted cycle is one with bus_gnt=1. In a granted cycle, mem_addr = GPR_BASE + idx*4 (idx zero-extended, shifted left 2).
  - Save, granted cycle: rf_raddr=idx, mem_we=1, mem_data=rf_rdata.
  - Restore, granted cycle: mem_we=0, mem_data=Z.
    - Responder read is combinational, so mem_data is valid in the same cycle.
    - rf_we=1, rf_waddr=idx, rf_wdata=mem_data; the RF captures at the clock edge.
  - Ungranted cycle: mem_we=0, mem_data=Z, rf_we=0, mem_addr=0, idx held. This is a stall with no data loss.
  - After a granted cycle:
    - if idx==LAST_IDX, go to DONE;
    - otherwise idx=idx+1.
- DONE:
  - done=1 for exactly one cycle; busy=1; bus_req=0; mem_we=0.
  - Next state is IDLE.
  - A new command is accepted no earlier than the cycle after DONE.
- Latency with bus_gnt held 1, accept at cycle 0:
  - granted XFER cycles 1..31 (idx 1..31);
  - done at cycle 32;
  - cmd_ready at cycle 33.
- Stalls: each ungranted XFER cycle adds exactly one cycle.
- Outputs rf_we and mem_we are never high in the same cycle.
- mem_addr never targets index 0 of the GPR window.

Optional Feature:
- Macro: CTX_TMP_EN.
- Defined:
  - The transfer continues after GPR index LAST_IDX with 32 temp words, t = 0..31, at mem_addr = TMP_BASE + t*4.
  - The extra RF bank is addressed as index 32+t: rf_raddr/rf_waddr widen to 6 bits, and bit 5 = 1 selects the temp bank.
  - idx runs FIRST_IDX..63; the temp-bank entry is idx 32..63, so the transition to DONE occurs after idx 63.
  - Granted cycles: 63; done at cycle 64 when ungated.
- Undefined:
  - rf index ports are 5 bits.
  - TMP_BASE is unused.
  - Only the GPR window is transferred.

Test Plan:
- Save, gnt=1: RF[i]=32'hA000_0000+i, cmd_op=0 at cycle 0 → writes at 0xffffc004..0xffffc07c on cycles 1..31, each with data A000_0000+i; done at cycle 32; responder GPR[5] reads A000_0005; address 0xffffc000 is never written.
- Restore, gnt=1: responder GPR[i]=~i preloaded, cmd_op=1 → rf_we cycles 1..31 with rf_waddr=i, rf_wdata=~i; mem_data never driven by ctx_mover.
- Grant stall: save with bus_gnt low on cycles 3,4,10 → mem_we=0 and Z on those cycles; idx held; done at cycle 35; all 31 words correct.
- Reset mid-op: rst at cycle 12 of a save → next cycle state IDLE, mem_we=0, bus_req=0, cmd_ready=1; a new save then completes normally.
- Back-to-back: cmd_valid held high across two saves → second accept at cycle 33; done pulses at 32 and 65; cmd_valid during busy is ignored.
- CTX_TMP_EN: restore with temp window word t=t*3 → rf_waddr 32+t gets 3t at addresses 0xffffc080+4t; done at cycle 64.

Source files
------------

// File: rtl/ctx_mover_if.sv
// Command handshake and shared-bus control between ctx_mover and the core/arbiter side.
// mem_data is a tristate bus and is kept as a plain inout port on ctx_mover.
interface ctx_mover_if;
    localparam int unsigned ADDR_W = 32;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic              busy;
    logic              done;
    logic              bus_req;
    logic              bus_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;

    modport master (
        input  cmd_valid, cmd_op, bus_gnt,
        output cmd_ready, busy, done, bus_req, mem_we, mem_addr
    );

    modport slave (
        output cmd_valid, cmd_op, bus_gnt,
        input  cmd_ready, busy, done, bus_req, mem_we, mem_addr
    );
endinterface

// File: rtl/ctx_mover.sv
// Saves/restores the core register file to/from the memory-mapped GPR window (x0 skipped).
// Optional macro CTX_TMP_EN extends the transfer with the 32-word temp bank (rf index 32..63).
module ctx_mover #(
    parameter logic [31:0] GPR_BASE  = 32'hffffc000,
`ifdef CTX_TMP_EN
    parameter logic [31:0] TMP_BASE  = 32'hffffc080,
    localparam int unsigned RF_AW    = 6,
`else
    localparam int unsigned RF_AW    = 5,
`endif
    parameter int unsigned FIRST_IDX = 1,
    parameter int unsigned LAST_IDX  = 31
) (
    input  logic               clk,
    input  logic               rst,
    ctx_mover_if.master        bus,
    inout  wire  [31:0]        mem_data,
    output logic [RF_AW-1:0]   rf_raddr,
    input  logic [31:0]        rf_rdata,
    output logic               rf_we,
    output logic [RF_AW-1:0]   rf_waddr,
    output logic [31:0]        rf_wdata
);
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned DATA_W = 32;

`ifdef CTX_TMP_EN
    localparam logic [IDX_W-1:0] END_IDX = IDX_W'(63);
`else
    localparam logic [IDX_W-1:0] END_IDX = IDX_W'(LAST_IDX);
`endif

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state, state_nxt;
    logic              op, op_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt, idx_step;
    logic [31:0]       win_addr;
    logic              we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op    <= 1'b0;
            idx   <= IDX_W'(FIRST_IDX);
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
            idx   <= idx_nxt;
        end
    end

    // Window address and successor index; the temp bank follows the last GPR at idx 32.
`ifdef CTX_TMP_EN
    assign win_addr = idx[5] ? TMP_BASE + {25'd0, idx[4:0], 2'b00}
                             : GPR_BASE + {24'd0, idx, 2'b00};
    assign idx_step = (idx == IDX_W'(LAST_IDX)) ? IDX_W'(32) : idx + IDX_W'(1);
`else
    assign win_addr = GPR_BASE + {24'd0, idx, 2'b00};
    assign idx_step = idx + IDX_W'(1);
`endif

    always_comb begin
        state_nxt     = state;
        op_nxt        = op;
        idx_nxt       = idx;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.bus_req   = 1'b0;
        bus.mem_addr  = '0;
        we            = 1'b0;
        rf_raddr      = '0;
        rf_we         = 1'b0;
        rf_waddr      = '0;
        rf_wdata      = '0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    op_nxt    = bus.cmd_op;
                    idx_nxt   = IDX_W'(FIRST_IDX);
                    state_nxt = XFER;
                end
            end
            XFER: begin
                bus.busy    = 1'b1;
                bus.bus_req = 1'b1;
                // Without grant everything is held: no strobe, no address, no RF write.
                if (bus.bus_gnt) begin
                    bus.mem_addr = win_addr;
                    if (!op) begin
                        we       = 1'b1;
                        rf_raddr = RF_AW'(idx);
                    end else begin
                        rf_we    = 1'b1;
                        rf_waddr = RF_AW'(idx);
                        rf_wdata = mem_data;
                    end
                    if (idx == END_IDX) state_nxt = DONE;
                    else                idx_nxt   = idx_step;
                end
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_we = we;
    assign mem_data   = we ? rf_rdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_ctx_mover.sv
// Directed bench for ctx_mover: save, restore, grant stalls, mid-op reset and back-to-back commands.
// Define CTX_TMP_EN for both bench and RTL to cover the temp-bank extension.
module tb_ctx_mover;
`ifdef CTX_TMP_EN
    localparam int unsigned END_IDX = 63;
    localparam int unsigned RFW     = 6;
`else
    localparam int unsigned END_IDX = 31;
    localparam int unsigned RFW     = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctx_mover_if bus();
    wire  [31:0]     mem_data;
    logic [RFW-1:0]  rf_raddr, rf_waddr;
    logic [31:0]     rf_rdata, rf_wdata;
    logic            rf_we;

    ctx_mover dut (
        .clk(clk), .rst(rst), .bus(bus), .mem_data(mem_data),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    // Register file and register-window responder models
    logic [31:0] rf  [0:63];
    logic [31:0] win [0:63];
    logic [31:0] win_off;
    logic        in_win;
    logic [5:0]  win_w;

    assign rf_rdata = rf[6'(rf_raddr)];
    assign win_off  = bus.mem_addr - 32'hffffc000;
    assign in_win   = (win_off < 32'd256);
    assign win_w    = win_off[7:2];
    assign mem_data = (bus.bus_req && bus.bus_gnt && !bus.mem_we && in_win) ? win[win_w] : 32'bz;

    always @(posedge clk) begin
        if (bus.mem_we && in_win) win[win_w] <= mem_data;
        if (rf_we) rf[6'(rf_waddr)] <= rf_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int i);
        if (i < 32) return 32'hffffc000 + 32'(i) * 32'd4;
        return 32'hffffc080 + 32'(i - 32) * 32'd4;
    endfunction

    function automatic logic [31:0] restore_val(input int i);
        if (i < 32) return ~32'(i);
        return 32'(3 * (i - 32));
    endfunction

    task automatic run_cmd(input string name, input logic op_in, input bit hold,
                           input int s0, input int s1, input int s2, input int rst_at,
                           input int exp_done, output int acc_cyc);
        int idx_e;
        bit fin;
        bit g;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op_in;
        bus.bus_gnt   = 1'b1;
        acc_cyc = -1;
        for (int w = 0; w < 4 && acc_cyc < 0; w++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) acc_cyc = cyc;
            else begin @(posedge clk); #1; end
        end
        if (acc_cyc < 0) begin
            check({name, " accept"}, 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        idx_e = 1;
        fin   = 1'b0;
        for (int c = 1; c <= 200 && !fin; c++) begin
            @(posedge clk); #1;
            if (rst) begin
                rst = 1'b0;
                @(negedge clk);
                check({name, " rst ready"},  32'(bus.cmd_ready), 32'd1);
                check({name, " rst busy"},   32'(bus.busy),      32'd0);
                check({name, " rst req"},    32'(bus.bus_req),   32'd0);
                check({name, " rst we"},     32'(bus.mem_we),    32'd0);
                check({name, " rst rf_we"},  32'(rf_we),         32'd0);
                return;
            end
            if (!hold) bus.cmd_valid = 1'b0;
            g = !(c == s0 || c == s1 || c == s2);
            bus.bus_gnt = g;
            @(negedge clk);
            if (idx_e <= int'(END_IDX)) begin
                check({name, " ready"}, 32'(bus.cmd_ready), 32'd0);
                check({name, " busy"},  32'(bus.busy),      32'd1);
                check({name, " req"},   32'(bus.bus_req),   32'd1);
                check({name, " done"},  32'(bus.done),      32'd0);
                if (g) begin
                    check({name, " addr"}, bus.mem_addr, addr_of(idx_e));
                    if (!op_in) begin
                        check({name, " we"},    32'(bus.mem_we), 32'd1);
                        check({name, " rf_we"}, 32'(rf_we),      32'd0);
                        check({name, " wdata"}, mem_data,        rf[idx_e]);
                    end else begin
                        check({name, " we"},       32'(bus.mem_we), 32'd0);
                        check({name, " rf_we"},    32'(rf_we),      32'd1);
                        check({name, " rf_waddr"}, 32'(rf_waddr),   32'(idx_e));
                        check({name, " rf_wdata"}, rf_wdata,        win[idx_e]);
                    end
                    idx_e++;
                end else begin
                    check({name, " stall we"},    32'(bus.mem_we), 32'd0);
                    check({name, " stall rf_we"}, 32'(rf_we),      32'd0);
                    check({name, " stall addr"},  bus.mem_addr,    32'd0);
                end
            end else begin
                check({name, " done"},       32'(bus.done),    32'd1);
                check({name, " done busy"},  32'(bus.busy),    32'd1);
                check({name, " done req"},   32'(bus.bus_req), 32'd0);
                check({name, " done we"},    32'(bus.mem_we),  32'd0);
                check({name, " done rf_we"}, 32'(rf_we),       32'd0);
                check({name, " done cycle"}, 32'(c),           32'(exp_done));
                fin = 1'b1;
            end
            if (c == rst_at) rst = 1'b1;
        end
        if (!fin) check({name, " done timeout"}, 32'(bus.done), 32'd1);
    endtask

    task automatic post_idle(input string name);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, " idle ready"}, 32'(bus.cmd_ready), 32'd1);
        check({name, " idle done"},  32'(bus.done),      32'd0);
        check({name, " idle busy"},  32'(bus.busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.bus_gnt   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rf[i]  = 32'ha000_0000 + 32'(i);
            win[i] = 32'h0;
        end
        win[0] = 32'hdead_beef;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready",    32'(bus.cmd_ready), 32'd1);
        check("reset busy",     32'(bus.busy),      32'd0);
        check("reset done",     32'(bus.done),      32'd0);
        check("reset req",      32'(bus.bus_req),   32'd0);
        check("reset we",       32'(bus.mem_we),    32'd0);
        check("reset addr",     bus.mem_addr,       32'd0);
        check("reset rf_we",    32'(rf_we),         32'd0);
        check("reset rf_raddr", 32'(rf_raddr),      32'd0);
        check("reset rf_waddr", 32'(rf_waddr),      32'd0);
        check("reset rf_wdata", rf_wdata,           32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Save with grant always high
        run_cmd("save", 1'b0, 1'b0, 0, 0, 0, 0, END_IDX + 1, a0);
        post_idle("save");
        check("save gpr5", win[5], 32'ha000_0005);
        check("save win0", win[0], 32'hdead_beef);
        for (int i = 1; i <= int'(END_IDX); i++) check("save word", win[i], 32'ha000_0000 + 32'(i));

        // Restore
        for (int i = 0; i < 64; i++) win[i] = restore_val(i);
        win[0] = 32'hdead_beef;
        rf[0]  = 32'h1234_5678;
        run_cmd("restore", 1'b1, 1'b0, 0, 0, 0, 0, END_IDX + 1, a0);
        post_idle("restore");
        check("restore x0", rf[0], 32'h1234_5678);
        for (int i = 1; i <= int'(END_IDX); i++) check("restore reg", rf[i], restore_val(i));

        // Save with grant stalls on cycles 3, 4, 10
        for (int i = 0; i < 64; i++) begin
            rf[i]  = 32'hb000_0000 + 32'(i);
            win[i] = 32'h0;
        end
        win[0] = 32'hdead_beef;
        run_cmd("stall", 1'b0, 1'b0, 3, 4, 10, 0, END_IDX + 4, a0);
        post_idle("stall");
        check("stall win0", win[0], 32'hdead_beef);
        for (int i = 1; i <= int'(END_IDX); i++) check("stall word", win[i], 32'hb000_0000 + 32'(i));

        // Reset at cycle 12 of a save, then a full save
        for (int i = 0; i < 64; i++) rf[i] = 32'hc000_0000 + 32'(i);
        run_cmd("rstmid", 1'b0, 1'b0, 0, 0, 0, 12, 0, a0);
        run_cmd("after_rst", 1'b0, 1'b0, 0, 0, 0, 0, END_IDX + 1, a0);
        post_idle("after_rst");
        for (int i = 1; i <= int'(END_IDX); i++) check("after_rst word", win[i], 32'hc000_0000 + 32'(i));

        // Back-to-back with cmd_valid held high
        for (int i = 0; i < 64; i++) rf[i] = 32'hd000_0000 + 32'(i);
        run_cmd("b2b_1", 1'b0, 1'b1, 0, 0, 0, 0, END_IDX + 1, a0);
        run_cmd("b2b_2", 1'b0, 1'b0, 0, 0, 0, 0, END_IDX + 1, a1);
        check("b2b accept gap", 32'(a1 - a0), 32'(END_IDX + 2));
        post_idle("b2b");
        check("b2b word7", win[7], 32'hd000_0007);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
